// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and the two's-complement negate helper.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Two's-complement negation of one XLEN-bit word.
  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
    return ~x + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit holding the architectural HI/LO
// registers. Shift-add multiply and restoring divide, one bit per cycle,
// followed by a single sign-correction cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]    r_a;
  logic [WIDTH-1:0]    r_b;
  logic                r_div;
  logic                r_sa;
  logic                r_sb;

  logic                w_signed;
  logic [WIDTH-1:0]    w_mag0;
  logic [WIDTH-1:0]    w_mag1;
  logic [WIDTH:0]      w_sum;
  logic [2*WIDTH-1:0]  w_mul_next;
  logic [WIDTH:0]      w_trial;
  logic [2*WIDTH-1:0]  w_div_next;
  logic [WIDTH-1:0]    w_lo_neg;
  logic [WIDTH-1:0]    w_hi_neg;
  logic [WIDTH-1:0]    w_prod_hi_neg;
  logic [WIDTH-1:0]    w_a_neg;

  // Operand magnitudes for the accepting edge.
  assign w_signed = ~op[0];
  assign w_mag0   = (w_signed && in0[WIDTH-1]) ? negate(in0) : in0;
  assign w_mag1   = (w_signed && in1[WIDTH-1]) ? negate(in1) : in1;

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring divide step: upper half is the partial remainder, lower half
  // shifts dividend bits out and quotient bits in.
  assign w_trial    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_b};
  assign w_div_next = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign correction; the 2*WIDTH product negate carries into the high word
  // only when the low word is zero.
  assign w_lo_neg      = negate(r_acc[WIDTH-1:0]);
  assign w_hi_neg      = negate(r_acc[2*WIDTH-1:WIDTH]);
  assign w_prod_hi_neg = ~r_acc[2*WIDTH-1:WIDTH] +
                         {{(WIDTH-1){1'b0}}, (r_acc[WIDTH-1:0] == '0)};
  assign w_a_neg       = negate(r_a);

  // Control FSM, iterative datapath and HI/LO architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_div   <= op[1];
                r_sa    <= w_signed & in0[WIDTH-1];
                r_sb    <= w_signed & in1[WIDTH-1];
                r_a     <= w_mag0;
                r_b     <= w_mag1;
                r_acc   <= {{WIDTH{1'b0}}, w_mag0};
                r_cnt   <= '0;
                busy    <= 1'b1;
                r_state <= ST_CALC;
              end
              OP_MTHI: hi <= in0;
              OP_MTLO: lo <= in0;
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          r_acc <= r_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (!r_div) begin
            if (r_sa ^ r_sb) begin
              hi <= w_prod_hi_neg;
              lo <= w_lo_neg;
            end else begin
              hi <= r_acc[2*WIDTH-1:WIDTH];
              lo <= r_acc[WIDTH-1:0];
            end
          end else if (r_b == '0) begin
            // Divide by zero returns the dividend as it was presented.
            hi <= r_sa ? w_a_neg : r_a;
            lo <= '1;
          end else begin
            lo <= (r_sa ^ r_sb) ? w_lo_neg : r_acc[WIDTH-1:0];
            hi <= r_sa ? w_hi_neg : r_acc[2*WIDTH-1:WIDTH];
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
